user_input_irq_ctrl: RTL
========================

// Module: user_input_irq_ctrl
// PURPOSE
//   Parametrised Avalon-MM slave for board keys and switches: synchronises and debounces
//   every input, and captures changes in a per-bit edge register.
//   Raises a maskable interrupt toward the HPS/Nios, either level-held until cleared or
//   as a one-cycle pulse (legacy mode). Sits between the board pins and the Avalon interconnect.
// PARAMETERS
//   NUM_KEYS          4   active-low push-buttons; W = NUM_KEYS+NUM_SWITCHES, 1..32
//   NUM_SWITCHES      4   active-high slide switches
//   SYNC_STAGES       2   synchroniser flops per input, >=2
//   DEBOUNCE_CYCLES   16  stable cycles required before accepting a change, >=1
// PORTS
//   clk           in   1     system clock
//   reset_n       in   1     synchronous, active-low reset
//   keys          in   NUM_KEYS      raw key pins, 0 = pressed
//   switches      in   NUM_SWITCHES  raw switch pins
//   avl_address   in   2     word address
//   avl_read      in   1     read strobe
//   avl_write     in   1     write strobe
//   avl_writedata in   32    write data
//   avl_readdata  out  32    read data, registered, read latency 1
//   avl_irq_n     out  1     interrupt, active-low
// BEHAVIOUR
//   Reset: every flop is cleared when reset_n=0 at a clk edge. Reset values:
//     - synchronisers and stable vector = inactive level (keys 1, switches 0)
//     - debounce counters = 0; EDGE = 0; MASK = all ones; CTRL = 0 (level mode)
//     - avl_readdata = 0; avl_irq_n = 1
//     Reset mid-operation discards pending edges and partial debounce counts.
//   Input vector: in = {switches, keys}; keys occupy bits [NUM_KEYS-1:0].
//   Debounce, per bit:
//     - if sync != stable, the counter increments; if sync == stable, the counter clears
//     - when counter == DEBOUNCE_CYCLES-1 and sync still differs: stable <= sync, counter clears
//     - a glitch shorter than DEBOUNCE_CYCLES cycles never reaches stable
//   Edge capture:
//     - chg = stable_next ^ stable; EDGE[i] is set the cycle stable[i] changes
//     - both press and release are captured
//   Latency: a pin change held steady appears in EDGE exactly
//     SYNC_STAGES + DEBOUNCE_CYCLES + 1 clk edges later. avl_irq_n follows on the same edge.
//   Register map (32-bit words; bits >= W read 0, writes to them ignored):
//     0 DATA  RO    {switches_stable, ~keys_stable}, i.e. 1 = pressed/on
//     1 EDGE  R/W1C writing 1 clears that bit
//     2 MASK  RW    1 = bit may interrupt
//     3 CTRL  RW    bit0 PULSE: 0 = level mode, 1 = pulse mode; other bits read 0
//   Writes to DATA are ignored.
//   Reads: avl_readdata is valid the cycle after avl_read and holds until the next read.
//     Read and write in the same cycle: the write takes effect, and readdata returns the
//     pre-write value.
//   Simultaneous W1C and new edge on the same bit: set wins, and the bit stays 1.
//   Interrupt, registered:
//     - level mode: avl_irq_n <= ~|(EDGE_next & MASK_next). It stays low until all masked
//       edge bits are cleared or masked.
//     - pulse mode: avl_irq_n <= ~|(chg & MASK). It is low for exactly one cycle per
//       debounced change; EDGE still records the change.
//     - writing MASK or CTRL re-evaluates the interrupt on the next edge. Unmasking a bit
//       with a pending edge asserts the interrupt in level mode.
//   Multiple bits changing on the same cycle produce one pulse or one level assertion,
//     with all bits set in EDGE.
// TESTING (defaults, DEBOUNCE_CYCLES=4 for the bench)
//   1 Reset with keys=4'b1111, switches=0 -> avl_irq_n=1, DATA=0, EDGE=0, MASK=8'hFF.
//   2 Level mode: switches=4'b0001 held -> avl_irq_n=0 after 7 clks; EDGE=8'h10.
//     Write EDGE=8'h10 -> avl_irq_n=1 on the next cycle.
//   3 Glitch: keys[1] low for 3 clks -> DATA, EDGE unchanged, avl_irq_n stays 1.
//     Low for 4+ clks -> DATA=8'h02, EDGE=8'h02.
//   4 Pulse mode (CTRL=1): keys=4'b1101 then release -> two single-cycle low pulses on
//     avl_irq_n; EDGE=8'h02.
//   5 MASK=8'h0F, switch change -> EDGE bit set, avl_irq_n stays 1.
//     Write MASK=8'hFF -> avl_irq_n=0 on the next cycle.
//   6 W1C on EDGE bit 0 on the same cycle bit 0 changes -> EDGE[0] stays 1.
//     Assert reset_n=0 mid-debounce -> all register reset values restored.

Source files
------------

// File: rtl/user_input_irq_ctrl.sv
// Avalon-MM slave for board keys/switches: synchronise, debounce, capture edges
// per bit and raise a maskable level or pulse interrupt.
module user_input_irq_ctrl #(
    parameter int unsigned NUM_KEYS        = 4,
    parameter int unsigned NUM_SWITCHES    = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_KEYS-1:0]     keys,
    input  logic [NUM_SWITCHES-1:0] switches,
    input  logic [1:0]              avl_address,
    input  logic                    avl_read,
    input  logic                    avl_write,
    input  logic [31:0]             avl_writedata,
    output logic [31:0]             avl_readdata,
    output logic                    avl_irq_n
);

    localparam int unsigned W     = NUM_KEYS + NUM_SWITCHES;
    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [W-1:0] IDLE = {{NUM_SWITCHES{1'b0}}, {NUM_KEYS{1'b1}}};

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_EDGE = 2'd1;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CTRL = 2'd3;

    logic [W-1:0]     pin_q;
    logic [W-1:0]     sync_q [SYNC_STAGES];
    logic [W-1:0]     sync_vec;
    logic [W-1:0]     stable_q;
    logic [W-1:0]     stable_next;
    logic [CNT_W-1:0] cnt_q [W];
    logic [CNT_W-1:0] cnt_next [W];
    logic [W-1:0]     edge_bits_q;
    logic [W-1:0]     edge_bits_next;
    logic [W-1:0]     mask_q;
    logic [W-1:0]     mask_next;
    logic             ctrl_q;
    logic             ctrl_next;
    logic [W-1:0]     chg;
    logic [W-1:0]     w1c;
    logic [W-1:0]     data_view;
    logic [31:0]      rd_mux;
    logic             irq_n_next;
    logic             unused_wdata;

    assign unused_wdata = ^avl_writedata;

    // Pin capture register followed by the synchroniser chain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pin_q <= IDLE;
            for (int s = 0; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= IDLE;
            end
        end else begin
            pin_q     <= {switches, keys};
            sync_q[0] <= pin_q;
            for (int s = 1; s < int'(SYNC_STAGES); s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign sync_vec = sync_q[SYNC_STAGES-1];

    // Per-bit debounce: accept a change after DEBOUNCE_CYCLES consecutive mismatches
    always_comb begin
        stable_next = stable_q;
        for (int i = 0; i < int'(W); i++) begin
            cnt_next[i] = '0;
            if (sync_vec[i] != stable_q[i]) begin
                if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    stable_next[i] = sync_vec[i];
                end else begin
                    cnt_next[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // Register writes, edge capture and interrupt evaluation
    always_comb begin
        w1c       = '0;
        mask_next = mask_q;
        ctrl_next = ctrl_q;
        if (avl_write) begin
            case (avl_address)
                ADDR_EDGE: w1c       = avl_writedata[W-1:0];
                ADDR_MASK: mask_next = avl_writedata[W-1:0];
                ADDR_CTRL: ctrl_next = avl_writedata[0];
                default:   ;
            endcase
        end
        chg            = stable_next ^ stable_q;
        edge_bits_next = (edge_bits_q & ~w1c) | chg;
        irq_n_next     = ctrl_next ? ~|(chg & mask_q) : ~|(edge_bits_next & mask_next);
    end

    // Keys are active-low on the pins; DATA reports 1 = pressed/on
    assign data_view = stable_q ^ IDLE;

    always_comb begin
        rd_mux = '0;
        case (avl_address)
            ADDR_DATA: rd_mux = 32'(data_view);
            ADDR_EDGE: rd_mux = 32'(edge_bits_q);
            ADDR_MASK: rd_mux = 32'(mask_q);
            ADDR_CTRL: rd_mux = {31'd0, ctrl_q};
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable_q     <= IDLE;
            edge_bits_q  <= '0;
            mask_q       <= '1;
            ctrl_q       <= 1'b0;
            avl_readdata <= '0;
            avl_irq_n    <= 1'b1;
            for (int i = 0; i < int'(W); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            stable_q    <= stable_next;
            edge_bits_q <= edge_bits_next;
            mask_q      <= mask_next;
            ctrl_q      <= ctrl_next;
            avl_irq_n   <= irq_n_next;
            if (avl_read) begin
                avl_readdata <= rd_mux;
            end
            for (int i = 0; i < int'(W); i++) begin
                cnt_q[i] <= cnt_next[i];
            end
        end
    end

endmodule
